int_sync_crossing_sink_gateway: RTL

Receive-side stage for synchronous interrupt crossings. It accepts the registered interrupt vector driven by an interrupt crossing source in another clock domain. It resynchronizes each line into the local clock with a multi-flop synchronizer and runs a per-line level-sensitive gateway. The gateway latches a request and holds it pending until claimed, then blocks re-raising until completion. It sits between the crossing source and the interrupt controller's pending and claim logic.

---
 rtl/int_sync_crossing_sink_gateway.sv | 103 ++++++++++
 1 files changed

// File: rtl/int_sync_crossing_sink_gateway.sv
// int_sync_crossing_sink_gateway
//
// Receive-side stage for synchronous interrupt crossings. Each interrupt
// line arriving from a crossing source in another clock domain is brought
// into the local clock through a SYNC_STAGES-deep flop chain. It then feeds
// an independent level-sensitive gateway:
//   IDLE -> PENDING -> INFLIGHT -> IDLE
// A request is latched once seen and held until the controller claims it.
// Re-raising is blocked until the controller signals completion.
//
// Parameters
//   NUM_INT      number of interrupt lines (>= 1)
//   SYNC_STAGES  synchronizer depth in flops (>= 2)
//
// Ports
//   clock         local-domain clock
//   reset         asynchronous active-low reset; clears every flop
//   auto_in_sync  interrupt levels from the source register (async to clock)
//   claim         single-cycle claim strobe per line
//   complete      single-cycle completion strobe per line
//   sync_level    final synchronizer stage per line (observe only)
//   pending       registered, high while the line is PENDING
//   in_flight     registered, high while the line is INFLIGHT

module int_sync_crossing_sink_gateway #(
  parameter int NUM_INT     = 2,
  parameter int SYNC_STAGES = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_INT-1:0] auto_in_sync,
  input  logic [NUM_INT-1:0] claim,
  input  logic [NUM_INT-1:0] complete,
  output logic [NUM_INT-1:0] sync_level,
  output logic [NUM_INT-1:0] pending,
  output logic [NUM_INT-1:0] in_flight
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    PENDING  = 2'b01,
    INFLIGHT = 2'b10
  } state_t;

  // Synchronizer chain: stage 0 captures the asynchronous level, and the
  // last stage is the only one allowed to reach logic.
  logic [NUM_INT-1:0] sync_p [SYNC_STAGES];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_p[s] <= '0;
      end
    end else begin
      sync_p[0] <= auto_in_sync;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_p[s] <= sync_p[s-1];
      end
    end
  end

  assign sync_level = sync_p[SYNC_STAGES-1];

  // Per-line gateway. The outputs are flops loaded from the next-state
  // decode, so they switch at the same edge as the state itself and have
  // no combinational path from any input.
  for (genvar i = 0; i < NUM_INT; i++) begin : g_line
    state_t state;
    state_t state_nxt;
    logic   pending_r;
    logic   in_flight_r;

    always_comb begin
      state_nxt = state;
      case (state)
        IDLE:     if (sync_level[i]) state_nxt = PENDING;
        // The claim wins over a coincident complete; the level dropping
        // does not release a latched request.
        PENDING:  if (claim[i])      state_nxt = INFLIGHT;
        // The complete wins over a coincident claim; the level is ignored
        // until the line returns to IDLE.
        INFLIGHT: if (complete[i])   state_nxt = IDLE;
        default:                     state_nxt = IDLE;
      endcase
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state       <= IDLE;
        pending_r   <= 1'b0;
        in_flight_r <= 1'b0;
      end else begin
        state       <= state_nxt;
        pending_r   <= (state_nxt == PENDING);
        in_flight_r <= (state_nxt == INFLIGHT);
      end
    end

    assign pending[i]   = pending_r;
    assign in_flight[i] = in_flight_r;
  end

endmodule
